// File: rtl/vga_ctrl_pkg.sv
// Shared constants for the VGA pattern sequencer.
//   - ASCII command bytes accepted from the UART receiver
//   - acknowledgement bytes returned on the UART transmitter
//   - ack-path FSM state encoding
//   - helper that computes the next auto-cycle pattern
package vga_ctrl_pkg;

   // UART command bytes
   localparam logic [7:0] ASCII_ZERO = 8'h30;  // '0'; '0'+k selects pattern k
   localparam logic [7:0] CMD_AUTO   = 8'h41;  // 'A'
   localparam logic [7:0] CMD_MANUAL = 8'h4D;  // 'M'

   // Acknowledgement bytes
   localparam logic [7:0] ACK_OK   = 8'h4B;    // 'K'
   localparam logic [7:0] ACK_ERR  = 8'h3F;    // '?'
   localparam logic [7:0] ACK_BUSY = 8'h42;    // 'B': UART request lost to a button

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_WAIT  = 2'd2
   } tx_state_e;

   // Auto-cycle sequence 1 -> 2 -> ... -> num-1 -> 1; blank (0) is never revisited.
   function automatic logic [7:0] next_auto_pattern(input logic [7:0] cur,
                                                    input logic [7:0] num);
      if ((cur == 8'd0) || (cur >= (num - 8'd1))) begin
         return 8'd1;
      end
      return cur + 8'd1;
   endfunction

endpackage

// File: rtl/uart_ack_sender.sv
// Ack path: sends one acknowledgement byte at a time to UART_Tx.
// An ack arriving while a byte is in flight is held in a one-entry buffer;
// a newer ack overwrites a buffered, unsent one.
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   i_ackValid      one-cycle request to send i_ackByte
//   i_ackByte       byte to acknowledge with
//   i_txDone        one-cycle pulse from UART_Tx: current byte finished
//   o_txStart       one-cycle start pulse to UART_Tx
//   o_txByte        byte being sent; stable from o_txStart until i_txDone
module uart_ack_sender
   import vga_ctrl_pkg::*;
(
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_ackValid,
   input  logic [7:0] i_ackByte,
   input  logic       i_txDone,
   output logic       o_txStart,
   output logic [7:0] o_txByte
);

   tx_state_e  r_state;
   logic       r_txStart;
   logic [7:0] r_txByte;
   logic       r_bufValid;
   logic [7:0] r_bufByte;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state    <= TX_IDLE;
         r_txStart  <= 1'b0;
         r_txByte   <= 8'h00;
         r_bufValid <= 1'b0;
         r_bufByte  <= 8'h00;
      end else begin
         r_txStart <= 1'b0;
         case (r_state)
            TX_IDLE: begin
               if (i_ackValid) begin
                  r_txByte <= i_ackByte;
                  r_state  <= TX_START;
               end
            end
            TX_START: begin
               r_txStart <= 1'b1;
               r_state   <= TX_WAIT;
               if (i_ackValid) begin
                  r_bufValid <= 1'b1;
                  r_bufByte  <= i_ackByte;
               end
            end
            TX_WAIT: begin
               if (i_txDone) begin
                  // An ack arriving with i_txDone is newer than anything buffered.
                  if (i_ackValid) begin
                     r_txByte   <= i_ackByte;
                     r_bufValid <= 1'b0;
                     r_state    <= TX_START;
                  end else if (r_bufValid) begin
                     r_txByte   <= r_bufByte;
                     r_bufValid <= 1'b0;
                     r_state    <= TX_START;
                  end else begin
                     r_state <= TX_IDLE;
                  end
               end else if (i_ackValid) begin
                  r_bufValid <= 1'b1;
                  r_bufByte  <= i_ackByte;
               end
            end
            default: r_state <= TX_IDLE;
         endcase
      end
   end

   assign o_txStart = r_txStart;
   assign o_txByte  = r_txByte;

endmodule

// File: rtl/vga_pattern_sequencer.sv
// Owns the VGA test-pattern select. Arbitrates button and UART requests,
// applies them only at a frame boundary (falling edge of vsync), optionally
// auto-cycles every FRAMES_PER_STEP boundaries and acknowledges UART bytes.
// Ports:
//   i_clk, i_reset             clock, synchronous active-high reset
//   i_btnStrobe/i_btnPattern   button pattern request
//   i_rxStrobe/i_rxByte        received UART byte
//   i_vs                       VGA vertical sync, active low
//   i_txDone                   UART_Tx byte complete
//   o_pattern                  applied pattern
//   o_pending                  request waiting for a frame boundary
//   o_autoMode                 auto-cycle mode active
//   o_txStart/o_txByte         ack byte handshake to UART_Tx
module vga_pattern_sequencer
   import vga_ctrl_pkg::*;
#(
   parameter int unsigned NUM_PATTERNS    = 4,
   parameter int unsigned FRAMES_PER_STEP = 120
) (
   input  logic       i_clk,
   input  logic       i_reset,
   input  logic       i_btnStrobe,
   input  logic [7:0] i_btnPattern,
   input  logic       i_rxStrobe,
   input  logic [7:0] i_rxByte,
   input  logic       i_vs,
   input  logic       i_txDone,
   output logic [7:0] o_pattern,
   output logic       o_pending,
   output logic       o_autoMode,
   output logic       o_txStart,
   output logic [7:0] o_txByte
);

   localparam int unsigned    CNT_W     = $clog2(FRAMES_PER_STEP) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAMES_PER_STEP - 1);
   localparam logic [7:0]     PAT_LIMIT = 8'(NUM_PATTERNS);

   logic             r_vs;
   logic [7:0]       r_pattern;
   logic [7:0]       r_next;
   logic             r_pending;
   logic             r_autoMode;
   logic [CNT_W-1:0] r_frameCnt;

   logic       w_boundary;
   logic       w_btnReq;
   logic       w_rxDigit;
   logic       w_rxAuto;
   logic       w_rxManual;
   logic       w_reqValid;
   logic [7:0] w_reqPattern;
   logic [7:0] w_ackByte;

   always_comb begin
      w_boundary   = r_vs & ~i_vs;
      w_btnReq     = i_btnStrobe && (i_btnPattern < PAT_LIMIT);
      w_rxDigit    = i_rxStrobe && (i_rxByte >= ASCII_ZERO) &&
                     (i_rxByte < (ASCII_ZERO + PAT_LIMIT));
      w_rxAuto     = i_rxStrobe && (i_rxByte == CMD_AUTO);
      w_rxManual   = i_rxStrobe && (i_rxByte == CMD_MANUAL);
      w_reqValid   = w_btnReq | w_rxDigit;
      // Button wins a same-cycle collision with a UART digit.
      w_reqPattern = w_btnReq ? i_btnPattern : (i_rxByte - ASCII_ZERO);

      w_ackByte = ACK_ERR;
      if (w_rxDigit) begin
         w_ackByte = w_btnReq ? ACK_BUSY : ACK_OK;
      end else if (w_rxAuto || w_rxManual) begin
         w_ackByte = ACK_OK;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_vs       <= 1'b1;
         r_pattern  <= 8'h00;
         r_next     <= 8'h00;
         r_pending  <= 1'b0;
         r_autoMode <= 1'b0;
         r_frameCnt <= '0;
      end else begin
         r_vs <= i_vs;

         if (w_boundary) begin
            if (r_pending) begin
               r_pattern  <= r_next;
               r_pending  <= 1'b0;
               r_frameCnt <= '0;
            end else if (r_autoMode) begin
               if (r_frameCnt == CNT_LAST) begin
                  r_pattern  <= next_auto_pattern(r_pattern, PAT_LIMIT);
                  r_frameCnt <= '0;
               end else begin
                  r_frameCnt <= r_frameCnt + 1'b1;
               end
            end
         end

         // Mode commands apply before a request so a same-cycle request
         // still ends in manual mode. Later assignments win.
         if (w_rxAuto) begin
            r_autoMode <= 1'b1;
            r_frameCnt <= '0;
         end
         if (w_rxManual) begin
            r_autoMode <= 1'b0;
         end

         // A request coinciding with a boundary waits for the next one.
         if (w_reqValid) begin
            r_next     <= w_reqPattern;
            r_pending  <= 1'b1;
            r_autoMode <= 1'b0;
         end
      end
   end

   uart_ack_sender u_ack (
      .i_clk      (i_clk),
      .i_reset    (i_reset),
      .i_ackValid (i_rxStrobe),
      .i_ackByte  (w_ackByte),
      .i_txDone   (i_txDone),
      .o_txStart  (o_txStart),
      .o_txByte   (o_txByte)
   );

   assign o_pattern  = r_pattern;
   assign o_pending  = r_pending;
   assign o_autoMode = r_autoMode;

endmodule

// File: tb/tb_vga_pattern_sequencer.sv
// Directed self-checking bench for vga_pattern_sequencer (FRAMES_PER_STEP=3).
module tb_vga_pattern_sequencer;
   import vga_ctrl_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       btnStrobe = 1'b0;
   logic [7:0] btnPattern = 8'h00;
   logic       rxStrobe = 1'b0;
   logic [7:0] rxByte = 8'h00;
   logic       vs = 1'b1;
   logic       txDone = 1'b0;
   logic [7:0] pattern;
   logic       pending;
   logic       autoMode;
   logic       txStart;
   logic [7:0] txByte;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   vga_pattern_sequencer #(
      .NUM_PATTERNS    (4),
      .FRAMES_PER_STEP (3)
   ) dut (
      .i_clk        (clk),
      .i_reset      (reset),
      .i_btnStrobe  (btnStrobe),
      .i_btnPattern (btnPattern),
      .i_rxStrobe   (rxStrobe),
      .i_rxByte     (rxByte),
      .i_vs         (vs),
      .i_txDone     (txDone),
      .o_pattern    (pattern),
      .o_pending    (pending),
      .o_autoMode   (autoMode),
      .o_txStart    (txStart),
      .o_txByte     (txByte)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_boundary();
      vs = 1'b0;
      tick();
      vs = 1'b1;
      tick();
   endtask

   task automatic tx_finish();
      txDone = 1'b1;
      tick();
      txDone = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      n_tests++; if (pattern !== 8'h00) begin n_fail++; $display("FAIL reset_pattern got %h want 00", pattern); end
      n_tests++; if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got %b want 0", pending); end
      n_tests++; if (autoMode !== 1'b0) begin n_fail++; $display("FAIL reset_auto got %b want 0", autoMode); end
      n_tests++; if (txStart !== 1'b0) begin n_fail++; $display("FAIL reset_txStart got %b want 0", txStart); end
      n_tests++; if (txByte !== 8'h00) begin n_fail++; $display("FAIL reset_txByte got %h want 00", txByte); end
      reset = 1'b0;
      tick();
   endtask

   task automatic test_uart_pattern();
      rxStrobe = 1'b1; rxByte = 8'h32;
      tick();
      rxStrobe = 1'b0;
      n_tests++; if (pending !== 1'b1) begin n_fail++; $display("FAIL uart2_pending got %b want 1", pending); end
      n_tests++; if (pattern !== 8'h00) begin n_fail++; $display("FAIL uart2_pattern_early got %h want 00", pattern); end
      n_tests++; if (txByte !== 8'h4B) begin n_fail++; $display("FAIL uart2_txByte got %h want 4B", txByte); end
      n_tests++; if (txStart !== 1'b0) begin n_fail++; $display("FAIL uart2_txStart_t1 got %b want 0", txStart); end
      tick();
      n_tests++; if (txStart !== 1'b1) begin n_fail++; $display("FAIL uart2_txStart_t2 got %b want 1", txStart); end
      tick();
      n_tests++; if (txStart !== 1'b0) begin n_fail++; $display("FAIL uart2_txStart_t3 got %b want 0", txStart); end
      n_tests++; if (pattern !== 8'h00) begin n_fail++; $display("FAIL uart2_pattern_wait got %h want 00", pattern); end
      do_boundary();
      n_tests++; if (pattern !== 8'h02) begin n_fail++; $display("FAIL uart2_pattern got %h want 02", pattern); end
      n_tests++; if (pending !== 1'b0) begin n_fail++; $display("FAIL uart2_pending_clr got %b want 0", pending); end
      tx_finish();
      n_tests++; if (dut.u_ack.r_state !== TX_IDLE) begin n_fail++; $display("FAIL uart2_idle got %0d want %0d", dut.u_ack.r_state, TX_IDLE); end
   endtask

   task automatic test_arbitration();
      btnStrobe = 1'b1; btnPattern = 8'd1;
      rxStrobe = 1'b1; rxByte = 8'h33;
      tick();
      btnStrobe = 1'b0; rxStrobe = 1'b0;
      n_tests++; if (txByte !== 8'h42) begin n_fail++; $display("FAIL arb_txByte got %h want 42", txByte); end
      tick();
      n_tests++; if (txStart !== 1'b1) begin n_fail++; $display("FAIL arb_txStart got %b want 1", txStart); end
      tick();
      tx_finish();
      do_boundary();
      n_tests++; if (pattern !== 8'h01) begin n_fail++; $display("FAIL arb_pattern got %h want 01", pattern); end
   endtask

   task automatic test_auto();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      rxStrobe = 1'b1; rxByte = 8'h41;
      tick();
      rxStrobe = 1'b0;
      n_tests++; if (autoMode !== 1'b1) begin n_fail++; $display("FAIL auto_on got %b want 1", autoMode); end
      n_tests++; if (txByte !== 8'h4B) begin n_fail++; $display("FAIL auto_ack got %h want 4B", txByte); end
      tick();
      tick();
      tx_finish();
      do_boundary();
      do_boundary();
      n_tests++; if (pattern !== 8'h00) begin n_fail++; $display("FAIL auto_b2 got %h want 00", pattern); end
      do_boundary();
      n_tests++; if (pattern !== 8'h01) begin n_fail++; $display("FAIL auto_b3 got %h want 01", pattern); end
      for (int i = 0; i < 3; i++) do_boundary();
      n_tests++; if (pattern !== 8'h02) begin n_fail++; $display("FAIL auto_b6 got %h want 02", pattern); end
      for (int i = 0; i < 3; i++) do_boundary();
      n_tests++; if (pattern !== 8'h03) begin n_fail++; $display("FAIL auto_b9 got %h want 03", pattern); end
      for (int i = 0; i < 3; i++) do_boundary();
      n_tests++; if (pattern !== 8'h01) begin n_fail++; $display("FAIL auto_wrap got %h want 01", pattern); end
      btnStrobe = 1'b1; btnPattern = 8'd2;
      tick();
      btnStrobe = 1'b0;
      n_tests++; if (autoMode !== 1'b0) begin n_fail++; $display("FAIL auto_btn_clear got %b want 0", autoMode); end
      n_tests++; if (pending !== 1'b1) begin n_fail++; $display("FAIL auto_btn_pending got %b want 1", pending); end
      do_boundary();
      n_tests++; if (pattern !== 8'h02) begin n_fail++; $display("FAIL auto_btn_pattern got %h want 02", pattern); end
      for (int i = 0; i < 3; i++) do_boundary();
      n_tests++; if (pattern !== 8'h02) begin n_fail++; $display("FAIL auto_stopped got %h want 02", pattern); end
   endtask

   task automatic test_latest_wins();
      btnStrobe = 1'b1; btnPattern = 8'd9;
      tick();
      btnStrobe = 1'b0;
      n_tests++; if (pending !== 1'b0) begin n_fail++; $display("FAIL btn_oor_pending got %b want 0", pending); end
      btnStrobe = 1'b1; btnPattern = 8'd1;
      tick();
      btnStrobe = 1'b0;
      rxStrobe = 1'b1; rxByte = 8'h33;
      tick();
      rxStrobe = 1'b0;
      do_boundary();
      n_tests++; if (pattern !== 8'h03) begin n_fail++; $display("FAIL latest_pattern got %h want 03", pattern); end
      tx_finish();
      btnStrobe = 1'b1; btnPattern = 8'd2;
      tick();
      vs = 1'b0; btnPattern = 8'd1;
      tick();
      vs = 1'b1; btnStrobe = 1'b0;
      n_tests++; if (pattern !== 8'h02) begin n_fail++; $display("FAIL same_cycle_pattern got %h want 02", pattern); end
      n_tests++; if (pending !== 1'b1) begin n_fail++; $display("FAIL same_cycle_pending got %b want 1", pending); end
      tick();
      do_boundary();
      n_tests++; if (pattern !== 8'h01) begin n_fail++; $display("FAIL same_cycle_next got %h want 01", pattern); end
   endtask

   task automatic test_ack_buffer();
      rxStrobe = 1'b1; rxByte = 8'h5A;
      tick();
      rxByte = 8'h37;
      tick();
      rxStrobe = 1'b0;
      n_tests++; if (txStart !== 1'b1 || txByte !== 8'h3F) begin n_fail++; $display("FAIL buf_first got start=%b byte=%h want 1/3F", txStart, txByte); end
      tick();
      tx_finish();
      tick();
      n_tests++; if (txStart !== 1'b1 || txByte !== 8'h3F) begin n_fail++; $display("FAIL buf_second got start=%b byte=%h want 1/3F", txStart, txByte); end
      tick();
      tx_finish();
      n_tests++; if (dut.u_ack.r_state !== TX_IDLE) begin n_fail++; $display("FAIL buf_idle got %0d want %0d", dut.u_ack.r_state, TX_IDLE); end
      do_boundary();
      n_tests++; if (pattern !== 8'h01 || pending !== 1'b0) begin n_fail++; $display("FAIL buf_pattern got %h/%b want 01/0", pattern, pending); end
   endtask

   task automatic test_back_to_back();
      rxStrobe = 1'b1; rxByte = 8'h5A;
      tick();
      rxByte = 8'h4D;
      tick();
      rxStrobe = 1'b0;
      n_tests++; if (txStart !== 1'b1 || txByte !== 8'h3F) begin n_fail++; $display("FAIL b2b_first got start=%b byte=%h want 1/3F", txStart, txByte); end
      tick();
      n_tests++; if (txStart !== 1'b0 || txByte !== 8'h3F) begin n_fail++; $display("FAIL b2b_hold got start=%b byte=%h want 0/3F", txStart, txByte); end
      tx_finish();
      tick();
      n_tests++; if (txStart !== 1'b1 || txByte !== 8'h4B) begin n_fail++; $display("FAIL b2b_second got start=%b byte=%h want 1/4B", txStart, txByte); end
      tick();
      tx_finish();
   endtask

   task automatic test_reset_mid();
      rxStrobe = 1'b1; rxByte = 8'h32;
      tick();
      rxStrobe = 1'b0;
      tick();
      n_tests++; if (pending !== 1'b1 || txStart !== 1'b1) begin n_fail++; $display("FAIL mid_pre got pend=%b start=%b want 1/1", pending, txStart); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_tests++; if (pattern !== 8'h00) begin n_fail++; $display("FAIL mid_pattern got %h want 00", pattern); end
      n_tests++; if (pending !== 1'b0) begin n_fail++; $display("FAIL mid_pending got %b want 0", pending); end
      n_tests++; if (txStart !== 1'b0 || txByte !== 8'h00) begin n_fail++; $display("FAIL mid_tx got start=%b byte=%h want 0/00", txStart, txByte); end
      n_tests++; if (dut.u_ack.r_state !== TX_IDLE) begin n_fail++; $display("FAIL mid_idle got %0d want %0d", dut.u_ack.r_state, TX_IDLE); end
      tick();
      do_boundary();
      n_tests++; if (pattern !== 8'h00) begin n_fail++; $display("FAIL mid_lost got %h want 00", pattern); end
   endtask

   initial begin
      test_reset();
      test_uart_pattern();
      test_arbitration();
      test_auto();
      test_latest_wins();
      test_ack_buffer();
      test_back_to_back();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
